// File: rtl/reg_file.sv
// reg_file: integer register file with combinational read ports, optional
// write-to-read forwarding and a multi-cycle clear sequencer that zeroes x1..x(NREGS-1).
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | normal operation: writes and forwarding enabled
//   S_CLEAR | zeroing mem[cnt_q] each cycle; writes and clr_req ignored
module reg_file #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter bit BYPASS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     idata,
   output logic [XLEN-1:0] rv1,
   output logic [XLEN-1:0] rv2,
   input  logic            wb_en,
   input  logic [XLEN-1:0] wb_data,
   input  logic            clr_req,
   output logic            busy,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data
);
   localparam int AW = $clog2(NREGS);
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t          state_q;
   logic [AW-1:0]   cnt_q;
   logic            busy_q;
   logic [XLEN-1:0] mem_q [NREGS];

   logic [AW-1:0] rs1_a, rs2_a, rd_a, dbg_a;
   logic          wr_en;
   logic          unused_bits;

   // Register indices are taken modulo NREGS.
   assign rs1_a = idata[15 +: AW];
   assign rs2_a = idata[20 +: AW];
   assign rd_a  = idata[7 +: AW];
   assign dbg_a = dbg_addr[AW-1:0];
   assign unused_bits = ^{idata, dbg_addr};

   assign wr_en = (state_q == S_IDLE) && wb_en && (rd_a != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (wr_en) mem_q[rd_a] <= wb_data;
               if (clr_req) begin
                  state_q <= S_CLEAR;
                  cnt_q   <= AW'(1);
                  busy_q  <= 1'b1;
               end
            end
            S_CLEAR: begin
               mem_q[cnt_q] <= '0;
               // Exit on the last index so the counter never wraps through 0.
               if (cnt_q == LAST) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + AW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;

   always_comb begin
      rv1 = (rs1_a == '0) ? '0 : mem_q[rs1_a];
      rv2 = (rs2_a == '0) ? '0 : mem_q[rs2_a];
      if (BYPASS && wr_en && (rd_a == rs1_a)) rv1 = wb_data;
      if (BYPASS && wr_en && (rd_a == rs2_a)) rv2 = wb_data;
   end

   assign dbg_data = (dbg_a == '0) ? '0 : mem_q[dbg_a];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: the driver queues expected values per cycle,
// a negedge monitor pops and compares them. A BYPASS=0 instance runs alongside.
module tb_reg_file;
   logic        clk, rst;
   logic [31:0] idata, wb_data;
   logic        wb_en, clr_req;
   logic [4:0]  dbg_addr;
   logic [31:0] rv1, rv2, dbg_data, rv1_nb, rv2_nb, dbg_nb;
   logic        busy, busy_nb;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   typedef struct {
      string       name;
      int          sig;
      logic [31:0] exp;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   reg_file #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst), .idata(idata), .rv1(rv1), .rv2(rv2),
      .wb_en(wb_en), .wb_data(wb_data), .clr_req(clr_req), .busy(busy),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   reg_file #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .idata(idata), .rv1(rv1_nb), .rv2(rv2_nb),
      .wb_en(wb_en), .wb_data(wb_data), .clr_req(clr_req), .busy(busy_nb),
      .dbg_addr(dbg_addr), .dbg_data(dbg_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ins(int rs1, int rs2, int rd);
      return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(int rs1, int rs2, int rd, bit we, logic [31:0] wd, bit cr, int da);
      idata    = ins(rs1, rs2, rd);
      wb_en    = we;
      wb_data  = wd;
      clr_req  = cr;
      dbg_addr = 5'(da);
   endtask

   // sig: 0 rv1, 1 rv2, 2 dbg_data, 3 busy, 4 rv2 of the BYPASS=0 instance
   task automatic chk(string n, int s, logic [31:0] e);
      exp_t x;
      x.name = n;
      x.sig  = s;
      x.exp  = e;
      x.cyc  = cyc;
      sb.push_back(x);
   endtask

   exp_t        m_e;
   logic [31:0] m_act;
   always @(negedge clk) begin
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
         m_e = sb.pop_front();
         case (m_e.sig)
            0:       m_act = rv1;
            1:       m_act = rv2;
            2:       m_act = dbg_data;
            3:       m_act = {31'd0, busy};
            default: m_act = rv2_nb;
         endcase
         n_chk++;
         if (m_e.cyc != cyc || m_act !== m_e.exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", m_e.name, m_e.cyc, m_act, m_e.exp);
         end
      end
   end

   initial begin
      rst = 1'b1;
      drv(5, 31, 0, 0, 0, 0, 5);
      step();
      chk("rst_rv1", 0, 0); chk("rst_rv2", 1, 0); chk("rst_dbg", 2, 0); chk("rst_busy", 3, 0);
      step();
      rst = 1'b0;
      chk("post_rst_rv1", 0, 0); chk("post_rst_rv2", 1, 0); chk("post_rst_busy", 3, 0);

      step();
      drv(3, 3, 3, 1, 32'hDEADBEEF, 0, 3);
      chk("byp_rv1", 0, 32'hDEADBEEF); chk("byp_rv2", 1, 32'hDEADBEEF);
      chk("nobyp_rv2", 4, 0); chk("dbg_not_bypassed", 2, 0);
      step();
      drv(3, 3, 0, 0, 0, 0, 3);
      chk("wr_rv1", 0, 32'hDEADBEEF); chk("wr_rv2", 1, 32'hDEADBEEF);
      chk("wr_nobyp_rv2", 4, 32'hDEADBEEF); chk("wr_dbg", 2, 32'hDEADBEEF);

      step();
      drv(0, 0, 0, 1, 32'h12345678, 0, 0);
      chk("x0_byp_rv1", 0, 0); chk("x0_byp_rv2", 1, 0);
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      chk("x0_rv1", 0, 0); chk("x0_dbg", 2, 0);

      for (int i = 1; i < 32; i++) begin
         step();
         drv(0, 0, i, 1, 32'h100 + i, 0, 0);
      end
      for (int i = 1; i < 32; i++) begin
         step();
         drv(i, 32 - i, 0, 0, 0, 0, i);
         chk("fill_dbg", 2, 32'h100 + i);
         chk("fill_rv1", 0, 32'h100 + i);
         chk("fill_rv2", 1, 32'h100 + 32 - i);
      end

      step();
      drv(0, 0, 0, 0, 0, 1, 31);
      chk("clr_req_busy", 3, 0);
      for (int k = 1; k < 32; k++) begin
         step();
         drv(k, (k == 3) ? 2 : k - 1, (k == 3) ? 2 : 0, k == 3, (k == 3) ? 32'h55 : 0, k == 10, 31);
         chk("clr_busy", 3, 1);
         chk("clr_dbg31", 2, 32'h11F);
         chk("clr_uncleared", 0, 32'h100 + k);
         chk("clr_cleared", 1, 0);
      end
      step();
      drv(0, 0, 0, 0, 0, 0, 31);
      chk("clr_done_busy", 3, 0); chk("clr_done_dbg31", 2, 0);
      for (int i = 1; i < 32; i++) begin
         step();
         drv(i, 0, 0, 0, 0, 0, i);
         chk("after_clr_dbg", 2, 0);
         chk("after_clr_rv1", 0, 0);
      end

      step();
      drv(9, 0, 9, 1, 32'hAAAA, 1, 9);
      chk("sim_byp", 0, 32'hAAAA); chk("sim_busy", 3, 0);
      for (int k = 1; k < 32; k++) begin
         step();
         drv(9, 0, 0, 0, 0, 0, 9);
         chk("sim_busy_clr", 3, 1);
         chk("sim_x9", 2, (k <= 9) ? 32'hAAAA : 32'h0);
      end
      step();
      drv(9, 0, 0, 0, 0, 0, 9);
      chk("sim_done_busy", 3, 0); chk("sim_done_x9", 0, 0);

      step();
      drv(0, 0, 0, 0, 0, 1, 0);
      chk("held_idle0", 3, 0);
      for (int k = 1; k < 32; k++) begin
         step();
         chk("held_busy", 3, 1);
      end
      step();
      chk("held_gap", 3, 0);
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      chk("held_restart", 3, 1);
      for (int k = 2; k < 32; k++) begin
         step();
         chk("held_busy2", 3, 1);
      end
      step();
      chk("held_done", 3, 0);

      step();
      drv(0, 0, 20, 1, 32'h1234, 0, 0);
      step();
      drv(20, 0, 0, 0, 0, 1, 20);
      chk("rmid_pre", 0, 32'h1234); chk("rmid_pre_busy", 3, 0);
      for (int k = 1; k < 10; k++) begin
         step();
         drv(20, 0, 0, 0, 0, 0, 20);
         chk("rmid_busy", 3, 1); chk("rmid_x20", 0, 32'h1234);
      end
      step();
      rst = 1'b1;
      chk("rmid_busy_rst", 3, 0); chk("rmid_rv1_rst", 0, 0); chk("rmid_dbg_rst", 2, 0);
      step();
      rst = 1'b0;
      drv(2, 0, 2, 1, 32'h2222, 0, 2);
      chk("rmid_idle", 3, 0); chk("rmid_wr_byp", 0, 32'h2222);
      step();
      drv(2, 20, 0, 0, 0, 0, 2);
      chk("rmid_wr_rv1", 0, 32'h2222); chk("rmid_wr_dbg", 2, 32'h2222);
      chk("rmid_x20_zero", 1, 0); chk("rmid_busy_end", 3, 0);

      step();
      for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
      if (sb.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
         $fatal(1, "scoreboard did not drain");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
